mem_port_arbiter: RTL and testbench

Sequencer and arbiter for the single shared memory port of the multicycle core. Accepts independent transactions from the instruction-fetch requester (read-only) and the data requester (load/store), grants one at a time, drives the memory port, waits out the fixed read latency and returns data with a one-cycle completion pulse. Sits between the control unit/datapath fetch and MDR paths and the unified instruction/data memory.

---
 rtl/mem_port_arbiter_if.sv | 64 ++++++
 rtl/mem_port_arbiter.sv | 153 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if
// Bundles the fetch requester, data requester and shared memory port signals
// of the multicycle core's memory arbiter.
//
// Parameters:
//   ADDR_W  address width
//   DATA_W  data width
//
// Signal groups:
//   fetch   i_req, i_addr -> i_gnt, i_done, i_rdata
//   data    d_req, d_we, d_addr, d_wdata -> d_gnt, d_done, d_rdata
//   memory  mem_en, mem_we, mem_addr, mem_wdata <- mem_rdata
//   status  busy
//
// Modports:
//   slave   the arbiter's view (serves the requesters, drives the memory)
//   master  the surroundings' view (requesters plus memory)

interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64
);
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic              i_gnt;
    logic              i_done;
    logic [DATA_W-1:0] i_rdata;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_gnt;
    logic              d_done;
    logic [DATA_W-1:0] d_rdata;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    logic              busy;

    modport slave (
        input  i_req, i_addr,
        output i_gnt, i_done, i_rdata,
        input  d_req, d_we, d_addr, d_wdata,
        output d_gnt, d_done, d_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata,
        output busy
    );

    modport master (
        output i_req, i_addr,
        input  i_gnt, i_done, i_rdata,
        output d_req, d_we, d_addr, d_wdata,
        input  d_gnt, d_done, d_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata,
        input  busy
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Sequences the single shared memory port between the instruction-fetch
// requester (read-only) and the data requester (load/store). One transaction
// at a time walks IDLE -> ISSUE -> (WAIT) -> DONE. Read data comes back
// MEM_LAT cycles after the mem_en cycle and is latched into the owner's
// rdata register; the owner gets a one-cycle done pulse.
//
// Parameters:
//   MEM_LAT  memory read latency in cycles (>= 1)
//   Address/data widths come from the mem_port_arbiter_if instance.
//
// Ports:
//   clk      rising-edge clock
//   Reset_n  synchronous active-low reset
//   bus      mem_port_arbiter_if.slave (requesters, memory port, busy)
//
// Build option:
//   ARB_ROUND_ROBIN_EN  when defined, simultaneous requests are granted to
//                       the requester not served last; when undefined, the
//                       data requester always wins over fetch.

module mem_port_arbiter #(
    parameter int MEM_LAT = 2
) (
    input  logic                clk,
    input  logic                Reset_n,
    mem_port_arbiter_if.slave   bus
);

    localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE
    } state_t;

    state_t           state;
    logic             owner_data;
    logic             cap_we;
    logic [CNT_W-1:0] cnt;
    logic             pick_data;

`ifdef ARB_ROUND_ROBIN_EN
    logic             last_data;
`endif

    // Arbitration decision used only when sampling requests in IDLE.
    always_comb begin
        pick_data = bus.d_req;
`ifdef ARB_ROUND_ROBIN_EN
        if (bus.i_req && bus.d_req) begin
            pick_data = !last_data;
        end
`endif
    end

    // Single registered FSM: every output is a flop, so mem_en/mem_we never
    // follow req combinationally. Strobes and done pulses default low and are
    // raised only for the one cycle they belong to.
    always_ff @(posedge clk) begin
        if (!Reset_n) begin
            state         <= IDLE;
            owner_data    <= 1'b0;
            cap_we        <= 1'b0;
            cnt           <= '0;
            bus.i_gnt     <= 1'b0;
            bus.i_done    <= 1'b0;
            bus.i_rdata   <= '0;
            bus.d_gnt     <= 1'b0;
            bus.d_done    <= 1'b0;
            bus.d_rdata   <= '0;
            bus.mem_en    <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            bus.busy      <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
            last_data     <= 1'b0;
`endif
        end else begin
            bus.mem_en <= 1'b0;
            bus.mem_we <= 1'b0;
            bus.i_done <= 1'b0;
            bus.d_done <= 1'b0;

            case (state)
                IDLE: begin
                    if (bus.i_req || bus.d_req) begin
                        owner_data <= pick_data;
`ifdef ARB_ROUND_ROBIN_EN
                        last_data  <= pick_data;
`endif
                        // The strobe for the ISSUE cycle is registered here.
                        bus.mem_en <= 1'b1;
                        bus.busy   <= 1'b1;
                        if (pick_data) begin
                            cap_we        <= bus.d_we;
                            bus.mem_we    <= bus.d_we;
                            bus.mem_addr  <= bus.d_addr;
                            bus.mem_wdata <= bus.d_wdata;
                            bus.d_gnt     <= 1'b1;
                        end else begin
                            // Fetch is read-only; write data is left as is.
                            cap_we       <= 1'b0;
                            bus.mem_addr <= bus.i_addr;
                            bus.i_gnt    <= 1'b1;
                        end
                        state <= ISSUE;
                    end
                end

                ISSUE: begin
                    if (cap_we) begin
                        bus.d_done <= 1'b1;
                        state      <= DONE;
                    end else begin
                        cnt   <= CNT_W'(MEM_LAT - 1);
                        state <= WAIT;
                    end
                end

                WAIT: begin
                    if (cnt == '0) begin
                        if (owner_data) begin
                            bus.d_rdata <= bus.mem_rdata;
                            bus.d_done  <= 1'b1;
                        end else begin
                            bus.i_rdata <= bus.mem_rdata;
                            bus.i_done  <= 1'b1;
                        end
                        state <= DONE;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end

                DONE: begin
                    bus.i_gnt <= 1'b0;
                    bus.d_gnt <= 1'b0;
                    bus.busy  <= 1'b0;
                    state     <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
// Self-checking bench for mem_port_arbiter. A behavioural memory answers the
// port with MEM_LAT latency (junk on the read bus otherwise). Each scenario
// is planned at transaction level from the arbitration and timing rules,
// producing per-cycle expectations which are compared at the falling edge.
// Honours ARB_ROUND_ROBIN_EN the same way the design does.

module tb_mem_port_arbiter;

    localparam int MEM_LAT = 2;
    localparam int NC      = 64;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    logic [63:0] exp_i_rdata;
    logic [63:0] exp_d_rdata;
    logic [63:0] ref_mem   [logic [31:0]];
    logic [63:0] mem_store [logic [31:0]];
    logic [63:0] rd_pipe   [MEM_LAT];

`ifdef ARB_ROUND_ROBIN_EN
    bit last_data_m;
`endif

    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(64)) bus ();

    mem_port_arbiter #(.MEM_LAT(MEM_LAT)) dut (
        .clk     (clk),
        .Reset_n (reset_n),
        .bus     (bus)
    );

    function automatic logic [63:0] default_word(input logic [31:0] a);
        return {a ^ 32'hA5A5_0000, ~a};
    endfunction

    function automatic logic [63:0] ref_read(input logic [31:0] a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return default_word(a);
    endfunction

    // Memory: writes land on the strobe edge, reads appear MEM_LAT cycles
    // after the strobe cycle; any other cycle shows random junk.
    always @(posedge clk) begin
        if (bus.mem_en && bus.mem_we) begin
            mem_store[bus.mem_addr] = bus.mem_wdata;
        end
        if (bus.mem_en && !bus.mem_we) begin
            rd_pipe[0] <= mem_store.exists(bus.mem_addr) ? mem_store[bus.mem_addr]
                                                          : default_word(bus.mem_addr);
        end else begin
            rd_pipe[0] <= {$urandom, $urandom};
        end
        for (int k = 1; k < MEM_LAT; k++) rd_pipe[k] <= rd_pipe[k-1];
    end

    assign bus.mem_rdata = rd_pipe[MEM_LAT-1];

    task automatic check_output(input string tag, input logic [63:0] observed,
                                input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_output({tag, " i_gnt"},     64'(bus.i_gnt),   64'd0);
        check_output({tag, " i_done"},    64'(bus.i_done),  64'd0);
        check_output({tag, " i_rdata"},   bus.i_rdata,      64'd0);
        check_output({tag, " d_gnt"},     64'(bus.d_gnt),   64'd0);
        check_output({tag, " d_done"},    64'(bus.d_done),  64'd0);
        check_output({tag, " d_rdata"},   bus.d_rdata,      64'd0);
        check_output({tag, " mem_en"},    64'(bus.mem_en),  64'd0);
        check_output({tag, " mem_we"},    64'(bus.mem_we),  64'd0);
        check_output({tag, " mem_addr"},  64'(bus.mem_addr), 64'd0);
        check_output({tag, " mem_wdata"}, bus.mem_wdata,    64'd0);
        check_output({tag, " busy"},      64'(bus.busy),    64'd0);
    endtask

    // Plans one scenario (fetch raised at cycle ri, data at cycle rd), then
    // drives it cycle by cycle and checks every output against the plan.
    // Cycle 0 is the first falling edge; reset is released there.
    task automatic apply_stimulus(input bit use_i, input int ri, input logic [31:0] ia,
                                  input bit use_d, input int rd, input bit dwe,
                                  input logic [31:0] da, input logic [63:0] dwd);
        bit          e_ig [NC];
        bit          e_dg [NC];
        bit          e_id [NC];
        bit          e_dd [NC];
        bit          e_en [NC];
        bit          e_we [NC];
        bit          e_busy [NC];
        logic [31:0] e_addr [NC];
        logic [63:0] e_wd [NC];
        bit          upd_i [NC];
        bit          upd_d [NC];
        logic [63:0] val_i [NC];
        logic [63:0] val_d [NC];
        int f, len, last, i_drop, d_drop;
        bit i_pend, d_pend, i_c, d_c, pick_d, we;

        for (int c = 0; c < NC; c++) begin
            e_ig[c] = 0; e_dg[c] = 0; e_id[c] = 0; e_dd[c] = 0;
            e_en[c] = 0; e_we[c] = 0; e_busy[c] = 0;
            e_addr[c] = '0; e_wd[c] = '0;
            upd_i[c] = 0; upd_d[c] = 0; val_i[c] = '0; val_d[c] = '0;
        end

        f = 0; i_pend = use_i; d_pend = use_d; i_drop = -1; d_drop = -1;
        while (i_pend || d_pend) begin
            i_c = i_pend && (ri <= f);
            d_c = d_pend && (rd <= f);
            if (!i_c && !d_c) begin
                f++;
                continue;
            end
`ifdef ARB_ROUND_ROBIN_EN
            pick_d = (i_c && d_c) ? !last_data_m : d_c;
            last_data_m = pick_d;
`else
            pick_d = d_c;
`endif
            we  = pick_d && dwe;
            len = we ? 3 : MEM_LAT + 3;
            e_en[f+1]   = 1;
            e_we[f+1]   = we;
            e_addr[f+1] = pick_d ? da : ia;
            e_wd[f+1]   = dwd;
            for (int k = f + 1; k < f + len; k++) begin
                e_busy[k] = 1;
                if (pick_d) e_dg[k] = 1; else e_ig[k] = 1;
            end
            if (pick_d) begin
                e_dd[f+len-1] = 1;
                d_drop = f + len - 1;
                d_pend = 0;
                if (we) begin
                    ref_mem[da] = dwd;
                end else begin
                    upd_d[f+len-1] = 1;
                    val_d[f+len-1] = ref_read(da);
                end
            end else begin
                e_id[f+len-1] = 1;
                i_drop = f + len - 1;
                i_pend = 0;
                upd_i[f+len-1] = 1;
                val_i[f+len-1] = ref_read(ia);
            end
            f += len;
        end
        last = f + 1;

        for (int c = 0; c <= last; c++) begin
            @(negedge clk);
            if (c == 0) reset_n = 1'b1;
            if (upd_i[c]) exp_i_rdata = val_i[c];
            if (upd_d[c]) exp_d_rdata = val_d[c];
            check_output($sformatf("c%0d i_gnt", c),   64'(bus.i_gnt),  64'(e_ig[c]));
            check_output($sformatf("c%0d d_gnt", c),   64'(bus.d_gnt),  64'(e_dg[c]));
            check_output($sformatf("c%0d i_done", c),  64'(bus.i_done), 64'(e_id[c]));
            check_output($sformatf("c%0d d_done", c),  64'(bus.d_done), 64'(e_dd[c]));
            check_output($sformatf("c%0d mem_en", c),  64'(bus.mem_en), 64'(e_en[c]));
            check_output($sformatf("c%0d mem_we", c),  64'(bus.mem_we), 64'(e_we[c]));
            check_output($sformatf("c%0d busy", c),    64'(bus.busy),   64'(e_busy[c]));
            check_output($sformatf("c%0d i_rdata", c), bus.i_rdata,     exp_i_rdata);
            check_output($sformatf("c%0d d_rdata", c), bus.d_rdata,     exp_d_rdata);
            if (e_en[c]) begin
                check_output($sformatf("c%0d mem_addr", c), 64'(bus.mem_addr), 64'(e_addr[c]));
                if (e_we[c])
                    check_output($sformatf("c%0d mem_wdata", c), bus.mem_wdata, e_wd[c]);
            end
            if (use_i && c == ri) begin
                bus.i_req  = 1'b1;
                bus.i_addr = ia;
            end
            if (c == i_drop) bus.i_req = 1'b0;
            if (use_d && c == rd) begin
                bus.d_req   = 1'b1;
                bus.d_we    = dwe;
                bus.d_addr  = da;
                bus.d_wdata = dwd;
            end
            if (c == d_drop) bus.d_req = 1'b0;
        end
    endtask

    initial begin
        bit          ui, ud;
        logic [31:0] ra_i, ra_d;

        bus.i_req = 1'b0; bus.i_addr = '0;
        bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
        exp_i_rdata = '0;
        exp_d_rdata = '0;
`ifdef ARB_ROUND_ROBIN_EN
        last_data_m = 1'b0;
`endif
        mem_store[32'h40] = 64'h0000_0000_00A0_0093;
        ref_mem[32'h40]   = 64'h0000_0000_00A0_0093;

        // Reset held with a fetch pending: nothing may leave the arbiter.
        bus.i_req  = 1'b1;
        bus.i_addr = 32'h40;
        repeat (2) begin
            @(negedge clk);
            check_all_zero("reset");
        end

        // Release reset into the pending fetch of 0x40.
        apply_stimulus(1, 0, 32'h40, 0, 0, 0, 32'h0, 64'h0);
        check_output("fetch40 i_rdata", bus.i_rdata, 64'h0000_0000_00A0_0093);

        // Reset during the WAIT of a load: no done, state back to IDLE.
        @(negedge clk);
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h200;
        @(negedge clk);
        check_output("rstw d_gnt", 64'(bus.d_gnt), 64'd1);
        check_output("rstw mem_en", 64'(bus.mem_en), 64'd1);
        check_output("rstw mem_addr", 64'(bus.mem_addr), 64'h200);
        @(negedge clk);
        check_output("rstw busy", 64'(bus.busy), 64'd1);
        check_output("rstw d_done", 64'(bus.d_done), 64'd0);
        reset_n = 1'b0;
        @(negedge clk);
        // All outputs, including both rdata registers, return to zero.
        check_all_zero("rstw");
        reset_n = 1'b1;
        bus.d_req = 1'b0;
        exp_i_rdata = '0;
        exp_d_rdata = '0;
`ifdef ARB_ROUND_ROBIN_EN
        last_data_m = 1'b0;
`endif
        @(negedge clk);
        check_output("rstw idle busy", 64'(bus.busy), 64'd0);
        check_output("rstw idle d_done", 64'(bus.d_done), 64'd0);
        check_output("rstw idle mem_en", 64'(bus.mem_en), 64'd0);

        // Store, then a load of the same word.
        apply_stimulus(0, 0, 32'h0, 1, 0, 1, 32'h100, 64'h0000_0000_DEAD_BEEF);
        apply_stimulus(0, 0, 32'h0, 1, 0, 0, 32'h100, 64'h0);

        // Three contention rounds with both requesters raised together.
        for (int r = 0; r < 3; r++) begin
            apply_stimulus(1, 0, 32'h40 + 32'(r * 8), 1, 0, 0, 32'h100, 64'h0);
        end

        // Data request arriving while a fetch waits for memory.
        apply_stimulus(1, 0, 32'h48, 1, 2, 0, 32'h100, 64'h0);

        // Randomised traffic over a small address pool.
        repeat (40) begin
            ui = 1'($urandom_range(0, 1));
            ud = 1'($urandom_range(0, 1));
            if (!ui && !ud) ud = 1'b1;
            ra_i = 32'($urandom_range(0, 7)) << 3;
            ra_d = 32'($urandom_range(0, 7)) << 3;
            apply_stimulus(ui, $urandom_range(0, 6), ra_i,
                           ud, $urandom_range(0, 6), 1'($urandom_range(0, 1)), ra_d,
                           {$urandom, $urandom});
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
